synthesijer_fadd_pipe: RTL and testbench
========================================

Name: synthesijer_fadd_pipe

Overview:
Native-RTL, fully pipelined IEEE-754 binary floating-point adder/subtractor. Format is parametrised by exponent and mantissa width. It replaces the vendor-IP-based fixed fp32 adder wrapper in Synthesijer-generated designs, so the library no longer depends on vendor IP. Over that wrapper it adds a per-operation add/sub select, exception flags, fixed documented latency and full reset of pipeline state. It accepts one operation per cycle and sits between the generated datapath registers with the same nd/valid contract.

Parameters:
EXP_W, 8, exponent field width (8 → fp32, 11 → fp64)
MAN_W, 23, stored fraction width (23 → fp32, 52 → fp64)
W, EXP_W+MAN_W+1, total word width; derived, do not override

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
a  in  W  operand A
b  in  W  operand B
op  in  1  0 = a+b, 1 = a−b; sampled with nd
nd  in  1  new data; a, b and op are captured on any rising edge where nd=1
result  out  W  sum/difference
valid  out  1  result and flags valid this cycle
flags  out  4  {invalid, overflow, underflow, inexact}; meaningful only when valid=1

Behaviour:
- Reset (reset=0, async): all pipeline registers are cleared; result=0, valid=0, flags=0. Any in-flight operations are discarded, and no valid pulse is produced for them after release.
- Latency is exactly 4 cycles: nd=1 at edge k gives valid=1 with the matching result at edge k+4. Throughput is 1/cycle. There is no backpressure and no stall. Each valid pulse is exactly one cycle per nd beat.
- When valid=0, result and flags hold their last values.
- op=1 is implemented by inverting b's sign in stage 1. All rules below apply to the effective operands.
- S1, unpack/compare:
  - Subnormal inputs (exp=0) are flushed to signed zero.
  - Classify each operand as zero/normal/inf/NaN.
  - Swap so that |X| ≥ |Y|, comparing by exponent then mantissa.
  - Compute the exponent difference d.
- S2, align: shift Y's significand (with hidden 1) right by d. Keep guard and round bits plus a sticky OR of all bits shifted out. If d ≥ MAN_W+3, Y collapses to sticky only.
- S3, add/sub: effective subtract when the signs differ. The magnitude result is never negative because of the S1 swap.
- S4, normalise/round/pack:
  - Leading-zero count, then left shift, or right shift by 1 on carry-out; adjust the exponent.
  - Round to nearest, ties to even. Rounding carry-out increments the exponent.
- Specials, resolved in S1 and carried alongside the data:
  - Any NaN input → canonical qNaN (sign 0, exp all 1, fraction MSB 1, rest 0); invalid=1.
  - +inf + −inf (effective) → canonical qNaN; invalid=1.
  - inf ± finite → that inf; no flags.
- Zero results:
  - Exact zero from x−x → +0.
  - (−0)+(−0) → −0.
  - (+0)+(−0) → +0.
- Overflow: biased exponent after rounding ≥ all-ones → ±inf; overflow=1, inexact=1.
- Underflow: normalised exponent ≤ 0 → signed zero (flush-to-zero, no subnormal outputs); underflow=1, inexact=1.
- inexact=1 whenever the guard, round or sticky bits are non-zero at rounding.
- Every pipeline stage registers its own valid bit. Data registers may load unconditionally; only the valid bits gate the output.
- Behaviour is identical for any legal EXP_W ≥ 4 and MAN_W ≥ 4. No constants may be hard-wired to the fp32 format.

Test Plan:
- Defaults, nd=1 once, a=0x3F800000, b=0x40000000, op=0 → exactly 4 cycles later valid=1 for 1 cycle, result=0x40400000, flags=0000.
- a=0x3F800000, b=0x3F800000, op=1 → result=0x00000000 (+0), flags=0.
- Rounding: a=0x3F800000 with b=0x33800000 → 0x3F800000 (tie to even), inexact=1. Same a with b=0x33800001 → 0x3F800001, inexact=1.
- Exceptions:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7F800000+0xFF800000 → 0x7FC00000, invalid=1.
  - 0x00000001+0x00000000 → 0x00000000, flags=0.
- Stream 10 back-to-back random normal pairs with nd held high; mid-stream pull reset low for 1 cycle at cycle 6 → results before reset match the reference model in order. No valid pulses appear for the discarded beats. valid=0 and result=0 during reset.
- EXP_W=11, MAN_W=52: 0x3FF0000000000000+0x4000000000000000 → 0x4008000000000000 after 4 cycles.

Source files
------------

// File: rtl/synthesijer_fadd_pipe.sv
// Fully pipelined IEEE-754 adder/subtractor with a parametrised format, flush-to-zero,
// round-to-nearest-even and a fixed 4-cycle nd-to-valid latency.
module synthesijer_fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         nd,
  output logic [W-1:0] result,
  output logic         valid,
  output logic [3:0]   flags
);
  localparam int SW  = MAN_W + 1;
  localparam int AW  = MAN_W + 3;
  localparam int NW  = MAN_W + 4;
  localparam int LZW = $clog2(NW + 1);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0]    EXP_MAX  = {{(XW-EXP_W){1'b0}}, EXP_ONES};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [W-1:0] a0, b0;
  logic         op0, v0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a0 <= '0; b0 <= '0; op0 <= 1'b0; v0 <= 1'b0;
    end else begin
      a0 <= a; b0 <= b; op0 <= op; v0 <= nd;
    end
  end

  logic             sa, sb, za, zb, ia, ib, na, nb, a_ge_b, sp_c;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [W-1:0]     spres_c;
  logic [3:0]       spflg_c;

  // Subnormals are flushed here, so magnitude compare on {exp, frac} is exact
  always_comb begin
    sa = a0[W-1];
    sb = b0[W-1] ^ op0;
    ea = a0[W-2:MAN_W];
    eb = b0[W-2:MAN_W];
    za = (ea == '0);
    zb = (eb == '0);
    fa = za ? '0 : a0[MAN_W-1:0];
    fb = zb ? '0 : b0[MAN_W-1:0];
    ia = (ea == EXP_ONES) && (fa == '0);
    ib = (eb == EXP_ONES) && (fb == '0);
    na = (ea == EXP_ONES) && (fa != '0);
    nb = (eb == EXP_ONES) && (fb != '0);
    a_ge_b = {ea, fa} >= {eb, fb};
    sp_c = 1'b1;
    spres_c = QNAN;
    spflg_c = 4'b1000;
    if (na || nb || (ia && ib && (sa != sb))) begin
      sp_c = 1'b1;
    end else if (ia) begin
      spres_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
      spflg_c = 4'b0000;
    end else if (ib) begin
      spres_c = {sb, EXP_ONES, {MAN_W{1'b0}}};
      spflg_c = 4'b0000;
    end else if (za && zb) begin
      spres_c = {sa & sb, {(W-1){1'b0}}};
      spflg_c = 4'b0000;
    end else begin
      sp_c = 1'b0;
    end
  end

  logic             s1_v, s1_sx, s1_sy, s1_sp;
  logic [EXP_W-1:0] s1_ex, s1_d;
  logic [SW-1:0]    s1_mx, s1_my;
  logic [W-1:0]     s1_spres;
  logic [3:0]       s1_spflg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v <= 1'b0; s1_sx <= 1'b0; s1_sy <= 1'b0; s1_sp <= 1'b0;
      s1_ex <= '0; s1_d <= '0; s1_mx <= '0; s1_my <= '0;
      s1_spres <= '0; s1_spflg <= '0;
    end else begin
      s1_v <= v0;
      s1_sp <= sp_c;
      s1_spres <= spres_c;
      s1_spflg <= spflg_c;
      if (a_ge_b) begin
        s1_sx <= sa; s1_ex <= ea; s1_mx <= {~za, fa};
        s1_sy <= sb; s1_my <= {~zb, fb}; s1_d <= ea - eb;
      end else begin
        s1_sx <= sb; s1_ex <= eb; s1_mx <= {~zb, fb};
        s1_sy <= sa; s1_my <= {~za, fa}; s1_d <= eb - ea;
      end
    end
  end

  logic [2*AW-1:0] ysh;
  logic [AW-1:0]   yal;
  logic            ystk;

  // Lower half of the double-width shift holds every bit pushed past the round bit
  always_comb begin
    ysh = {s1_my, 2'b00, {AW{1'b0}}} >> s1_d;
    if (XW'(s1_d) >= XW'(AW)) begin
      yal  = '0;
      ystk = |s1_my;
    end else begin
      yal  = ysh[2*AW-1:AW];
      ystk = |ysh[AW-1:0];
    end
  end

  logic             s2_v, s2_sx, s2_sub, s2_sp;
  logic [EXP_W-1:0] s2_ex;
  logic [NW-1:0]    s2_xa, s2_ya;
  logic [W-1:0]     s2_spres;
  logic [3:0]       s2_spflg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_v <= 1'b0; s2_sx <= 1'b0; s2_sub <= 1'b0; s2_sp <= 1'b0;
      s2_ex <= '0; s2_xa <= '0; s2_ya <= '0; s2_spres <= '0; s2_spflg <= '0;
    end else begin
      s2_v <= s1_v; s2_sx <= s1_sx; s2_sub <= s1_sx ^ s1_sy; s2_sp <= s1_sp;
      s2_ex <= s1_ex;
      s2_xa <= {s1_mx, 3'b000};
      s2_ya <= {yal, ystk};
      s2_spres <= s1_spres; s2_spflg <= s1_spflg;
    end
  end

  logic             s3_v, s3_s, s3_sp;
  logic [EXP_W-1:0] s3_ex;
  logic [NW:0]      s3_sum;
  logic [W-1:0]     s3_spres;
  logic [3:0]       s3_spflg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_v <= 1'b0; s3_s <= 1'b0; s3_sp <= 1'b0; s3_ex <= '0; s3_sum <= '0;
      s3_spres <= '0; s3_spflg <= '0;
    end else begin
      s3_v <= s2_v; s3_s <= s2_sx; s3_sp <= s2_sp; s3_ex <= s2_ex;
      s3_sum <= s2_sub ? ({1'b0, s2_xa} - {1'b0, s2_ya}) : ({1'b0, s2_xa} + {1'b0, s2_ya});
      s3_spres <= s2_spres; s3_spflg <= s2_spflg;
    end
  end

  logic [LZW-1:0]   lz;
  logic             hit, rnd_up, inexact;
  logic [NW-1:0]    norm;
  logic [XW-1:0]    exp_n, exp_r;
  logic [SW:0]      mant_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res4;
  logic [3:0]       flg4;

  // Exponents are carried two bits wider so a deep cancellation shows up as a negative value
  always_comb begin
    lz = '0;
    hit = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!hit && s3_sum[i]) begin
        lz = LZW'(NW - 1 - i);
        hit = 1'b1;
      end
    end
    if (s3_sum[NW]) begin
      norm  = {s3_sum[NW:2], s3_sum[1] | s3_sum[0]};
      exp_n = XW'(s3_ex) + XW'(1);
    end else begin
      norm  = s3_sum[NW-1:0] << lz;
      exp_n = XW'(s3_ex) - XW'(lz);
    end
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact = |norm[2:0];
    mant_r  = {1'b0, norm[NW-1:3]} + (SW+1)'(rnd_up);
    exp_r   = exp_n + XW'(mant_r[SW]);
    frac    = mant_r[SW] ? mant_r[SW-1:1] : mant_r[SW-2:0];
    if (s3_sp) begin
      res4 = s3_spres;
      flg4 = s3_spflg;
    end else if (s3_sum == '0) begin
      res4 = '0;
      flg4 = 4'b0000;
    end else if (exp_n[XW-1] || (exp_n == '0)) begin
      res4 = {s3_s, {(W-1){1'b0}}};
      flg4 = 4'b0011;
    end else if (exp_r >= EXP_MAX) begin
      res4 = {s3_s, EXP_ONES, {MAN_W{1'b0}}};
      flg4 = 4'b0101;
    end else begin
      res4 = {s3_s, exp_r[EXP_W-1:0], frac};
      flg4 = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0; flags <= '0; valid <= 1'b0;
    end else begin
      valid <= s3_v;
      if (s3_v) begin
        result <= res4;
        flags  <= flg4;
      end
    end
  end

endmodule

// File: tb/tb_synthesijer_fadd_pipe.sv
// Self-checking bench: directed corner cases, an fp64 smoke test and random streams
// compared against an exact real-arithmetic reference with round-to-nearest-even.
module tb_synthesijer_fadd_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic        op = 1'b0, nd = 1'b0, valid;
  logic [3:0]  flags;
  logic [63:0] a64 = '0, b64 = '0, result64;
  logic        op64 = 1'b0, nd64 = 1'b0, valid64;
  logic [3:0]  flags64;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  synthesijer_fadd_pipe dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .nd(nd),
    .result(result), .valid(valid), .flags(flags)
  );

  synthesijer_fadd_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .reset(reset), .a(a64), .b(b64), .op(op64), .nd(nd64),
    .result(result64), .valid(valid64), .flags(flags64)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact sum in double precision (operands kept close enough to be exact),
  // then rounded to 24 significant bits with ties to even. Returns {flags, result}.
  function automatic logic [35:0] ref_fadd(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic sx, sy, xz, yz, xi, yi, xn, yn, up;
    int ex, ey, e;
    real rx, ry, rs;
    logic [63:0] db;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] m;
    sx = x[31];
    sy = y[31] ^ sub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yi && (sx != sy))) return {4'b1000, 32'h7FC00000};
    if (xi) return {4'b0000, sx, 8'hFF, 23'h0};
    if (yi) return {4'b0000, sy, 8'hFF, 23'h0};
    if (xz && yz) return {4'b0000, sx & sy, 31'h0};
    rx = xz ? 0.0 : $bitstoreal({sx, 11'(ex + 896), x[22:0], 29'h0});
    ry = yz ? 0.0 : $bitstoreal({sy, 11'(ey + 896), y[22:0], 29'h0});
    rs = rx + ry;
    if (rs == 0.0) return {4'b0000, 32'h0};
    db = $realtobits(rs);
    e = int'(db[62:52]) - 1023 + 127;
    if (e <= 0) return {4'b0011, db[63], 31'h0};
    keep = {1'b1, db[51:29]};
    rem = db[28:0];
    up = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    m = {1'b0, keep} + 25'(up);
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {4'b0101, db[63], 8'hFF, 23'h0};
    return {3'b000, rem != 0, db[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand(input bit specials);
    logic [31:0] sp [7];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00001, 32'h00000005, 32'h80000003};
    if (specials && ($urandom_range(0, 7) == 0)) return sp[$urandom_range(0, 6)];
    return {1'($urandom_range(0, 1)), 8'($urandom_range(112, 140)), 23'($urandom)};
  endfunction

  task automatic apply_stimulus(input string tag, input logic [31:0] x, input logic [31:0] y,
                                input logic sub, input logic [31:0] eres, input logic [3:0] eflg);
    @(negedge clk);
    a = x; b = y; op = sub; nd = 1'b1;
    @(posedge clk);
    #1 nd = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 check_output({tag, "/early_valid"}, 64'(valid), 64'(0));
    end
    @(posedge clk);
    #1;
    check_output({tag, "/valid"}, 64'(valid), 64'(1));
    check_output({tag, "/result"}, 64'(result), 64'(eres));
    check_output({tag, "/flags"}, 64'(flags), 64'(eflg));
    @(posedge clk);
    #1;
    check_output({tag, "/pulse_end"}, 64'(valid), 64'(0));
    check_output({tag, "/hold"}, 64'(result), 64'(eres));
  endtask

  task automatic stream_run(input string tag, input int n, input int rst_cycle, input bit specials);
    logic [35:0] expq[$];
    int          dueq[$];
    logic [35:0] e;
    for (int c = 0; c < n + 8; c++) begin
      @(negedge clk);
      if (c == rst_cycle) begin
        reset = 1'b0;
        #1;
        check_output({tag, "/rst_valid"}, 64'(valid), 64'(0));
        check_output({tag, "/rst_result"}, 64'(result), 64'(0));
        check_output({tag, "/rst_flags"}, 64'(flags), 64'(0));
        expq.delete();
        dueq.delete();
      end else begin
        reset = 1'b1;
      end
      if (c < n) begin
        a = rand_operand(specials);
        b = rand_operand(specials);
        op = 1'($urandom_range(0, 1));
        nd = 1'b1;
      end else begin
        nd = 1'b0;
      end
      @(posedge clk);
      #1;
      if (reset && nd) begin
        expq.push_back(ref_fadd(a, b, op));
        dueq.push_back(c + 4);
      end
      if ((dueq.size() > 0) && (dueq[0] == c)) begin
        e = expq.pop_front();
        void'(dueq.pop_front());
        check_output({tag, "/valid"}, 64'(valid), 64'(1));
        check_output({tag, "/result"}, 64'(result), 64'(e[31:0]));
        check_output({tag, "/flags"}, 64'(flags), 64'(e[35:32]));
      end else begin
        check_output({tag, "/idle_valid"}, 64'(valid), 64'(0));
      end
    end
    nd = 1'b0;
    reset = 1'b1;
    check_output({tag, "/drained"}, 64'(expq.size()), 64'(0));
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_output("reset/valid", 64'(valid), 64'(0));
    check_output("reset/result", 64'(result), 64'(0));
    check_output("reset/flags", 64'(flags), 64'(0));
    check_output("reset/valid64", 64'(valid64), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    apply_stimulus("x_minus_x", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    apply_stimulus("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    apply_stimulus("round_up", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    apply_stimulus("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    apply_stimulus("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    apply_stimulus("subnormal_flush", 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    apply_stimulus("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    apply_stimulus("mixed_zeros", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    apply_stimulus("underflow", 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    apply_stimulus("inf_minus_fin", 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
    apply_stimulus("nan_in", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);

    stream_run("stream_reset", 10, 6, 1'b0);
    stream_run("stream_random", 40, -1, 1'b1);

    @(negedge clk);
    a64 = 64'h3FF0000000000000; b64 = 64'h4000000000000000; op64 = 1'b0; nd64 = 1'b1;
    @(posedge clk);
    #1 nd64 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 check_output("fp64/early_valid", 64'(valid64), 64'(0));
    end
    @(posedge clk);
    #1;
    check_output("fp64/valid", 64'(valid64), 64'(1));
    check_output("fp64/result", result64, 64'h4008000000000000);
    check_output("fp64/flags", 64'(flags64), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
